// File: rtl/icache_dm_if.sv
// Fetch-side and refill-side signals of the direct-mapped instruction cache.
// slave is the cache's view; master is the fetch stage / memory environment.
interface icache_dm_if;
   logic        icache_req;
   logic [31:0] icache_addr;
   logic        icache_ready;
   logic        icache_resp_valid;
   logic [31:0] icache_inst;
   logic        icache_inv;
   logic        mem_rd_req;
   logic [31:0] mem_rd_addr;
   logic        mem_rd_ready;
   logic        mem_rd_valid;
   logic [31:0] mem_rd_data;
   logic        mem_rd_last;

   modport slave (
      input  icache_req, icache_addr, icache_inv,
      input  mem_rd_ready, mem_rd_valid, mem_rd_data, mem_rd_last,
      output icache_ready, icache_resp_valid, icache_inst,
      output mem_rd_req, mem_rd_addr
   );

   modport master (
      output icache_req, icache_addr, icache_inv,
      output mem_rd_ready, mem_rd_valid, mem_rd_data, mem_rd_last,
      input  icache_ready, icache_resp_valid, icache_inst,
      input  mem_rd_req, mem_rd_addr
   );
endinterface

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with burst line refill.
// Define ICACHE_PERF_EN to add the perf_hit_cnt/perf_miss_cnt lookup counters.
module icache_dm #(
   parameter int unsigned LINES      = 16,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        resetn,
   icache_dm_if.slave  bus
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] perf_hit_cnt,
   output logic [31:0] perf_miss_cnt
`endif
);
   localparam int unsigned WB  = $clog2(LINE_WORDS);
   localparam int unsigned OFF = WB + 2;
   localparam int unsigned IDX = $clog2(LINES);
   localparam int unsigned TAG = 32 - IDX - OFF;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOOKUP   = 3'd1;
   localparam logic [2:0] S_MISS_REQ = 3'd2;
   localparam logic [2:0] S_REFILL   = 3'd3;
   localparam logic [2:0] S_RESP     = 3'd4;

   logic [2:0]       r_state;
   logic [31:2]      r_req_addr;
   logic [LINES-1:0] r_valid;
   logic [TAG-1:0]   r_tag  [LINES];
   logic [31:0]      r_data [LINES][LINE_WORDS];
   logic             r_inv_pend;
   logic             r_resp_valid;
   logic [31:0]      r_inst;
   logic [31:0]      r_pend;
   logic             r_mem_req;
   logic [31:0]      r_mem_addr;
   logic [WB-1:0]    r_beat;

   logic [TAG-1:0]   w_tag;
   logic [IDX-1:0]   w_idx;
   logic [WB-1:0]    w_off;
   logic             w_hit;
   logic [31:0]      w_hit_word;
   logic             w_beat;
   logic             w_last_beat;
   logic             w_off_beat;
   logic             w_unused;

   assign w_tag       = r_req_addr[31 -: TAG];
   assign w_idx       = r_req_addr[OFF +: IDX];
   assign w_off       = r_req_addr[2 +: WB];
   assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_hit_word  = r_data[w_idx][w_off];
   assign w_beat      = (r_state == S_REFILL) && bus.mem_rd_valid;
   assign w_last_beat = w_beat && bus.mem_rd_last;
   assign w_off_beat  = (r_beat == w_off);
   assign w_unused    = &{1'b0, bus.icache_addr[1:0]};

   assign bus.icache_ready      = (r_state == S_IDLE);
   assign bus.icache_resp_valid = r_resp_valid;
   assign bus.icache_inst       = r_inst;
   assign bus.mem_rd_req        = r_mem_req;
   assign bus.mem_rd_addr       = r_mem_addr;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_req_addr   <= '0;
         r_valid      <= '0;
         r_inv_pend   <= 1'b0;
         r_resp_valid <= 1'b0;
         r_inst       <= '0;
         r_pend       <= '0;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= '0;
         r_beat       <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.icache_req) begin
                  r_req_addr <= bus.icache_addr[31:2];
                  r_state    <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (w_hit) begin
                  r_inst       <= w_hit_word;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else begin
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= {w_tag, w_idx, {OFF{1'b0}}};
                  r_state    <= S_MISS_REQ;
               end
            end
            S_MISS_REQ: begin
               if (bus.mem_rd_ready) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (bus.mem_rd_valid) begin
                  r_beat <= r_beat + WB'(1);
                  if (w_off_beat) r_pend <= bus.mem_rd_data;
                  if (bus.mem_rd_last) begin
                     // requested word may be arriving on this very beat
                     r_inst       <= w_off_beat ? bus.mem_rd_data : r_pend;
                     r_resp_valid <= 1'b1;
                     r_inv_pend   <= 1'b0;
                     r_state      <= S_RESP;
                  end
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase

         // An invalidate during a refill also vetoes validating the incoming line.
         if (bus.icache_inv) begin
            r_valid <= '0;
            if ((r_state == S_MISS_REQ) || ((r_state == S_REFILL) && !w_last_beat))
               r_inv_pend <= 1'b1;
         end else if (w_last_beat && !r_inv_pend) begin
            r_valid[w_idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_beat) r_data[w_idx][r_beat] <= bus.mem_rd_data;
      if (w_last_beat) r_tag[w_idx] <= w_tag;
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (r_state == S_LOOKUP) begin
         if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
         else       r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign perf_hit_cnt  = r_hit_cnt;
   assign perf_miss_cnt = r_miss_cnt;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: scoreboard of expected instructions checked on each response.
module tb_icache_dm;
   logic clk;
   logic resetn;
   int   n_checks;
   int   n_fail;
   int   n_resp;
   int   n_fetch;
   int   hit_exp;
   int   miss_exp;
   int   tb_beat;
   logic [31:0] sb_q[$];

   icache_dm_if bus();

`ifdef ICACHE_PERF_EN
   logic [31:0] perf_hit;
   logic [31:0] perf_miss;
`endif

   icache_dm #(.LINES(16), .LINE_WORDS(4)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .bus          (bus)
`ifdef ICACHE_PERF_EN
      ,
      .perf_hit_cnt (perf_hit),
      .perf_miss_cnt(perf_miss)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] la;
      la = {a[31:2], 2'b00};
      if (la[31:4] == 28'd0) return 32'h11 * (32'(la[3:2]) + 32'd1);
      return la ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every response pops the oldest expected instruction.
   always @(negedge clk) begin
      if (resetn === 1'b1 && bus.icache_resp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("resp_unexpected", 32'(bus.icache_resp_valid), 32'd0);
         end else begin
            chk("resp_inst", bus.icache_inst, sb_q.pop_front());
            n_resp++;
         end
      end
   end

   always @(posedge clk or negedge resetn) begin
      if (!resetn) tb_beat <= 0;
      else if (bus.mem_rd_valid) begin
         assert (!bus.mem_rd_last || tb_beat == 3) else begin
            n_fail++;
            $error("FAIL last_beat_pos: observed=%0d expected=3", tb_beat);
         end
         tb_beat <= (tb_beat + 1) % 4;
      end
   end

   task automatic fetch(input logic [31:0] addr, input bit miss, input int stall,
                        input int inv_beat, input bit inv_lookup);
      logic [31:0] line;
      line = addr & 32'hFFFF_FFF0;
      @(negedge clk);
      for (int n = 0; n < 20 && bus.icache_ready !== 1'b1; n++) @(negedge clk);
      chk("ready_idle", 32'(bus.icache_ready), 32'd1);
      bus.icache_req  = 1'b1;
      bus.icache_addr = addr;
      sb_q.push_back(mem_word(addr));
      n_fetch++;
      if (miss) miss_exp++; else hit_exp++;
      @(negedge clk);
      bus.icache_req  = 1'b0;
      bus.icache_addr = $urandom;
      chk("ready_lookup", 32'(bus.icache_ready), 32'd0);
      if (inv_lookup) bus.icache_inv = 1'b1;
      @(negedge clk);
      bus.icache_inv = 1'b0;
      if (!miss) begin
         chk("hit_resp_valid", 32'(bus.icache_resp_valid), 32'd1);
         chk("hit_no_memreq", 32'(bus.mem_rd_req), 32'd0);
      end else begin
         chk("miss_req", 32'(bus.mem_rd_req), 32'd1);
         chk("miss_addr", bus.mem_rd_addr, line);
         chk("miss_no_resp", 32'(bus.icache_resp_valid), 32'd0);
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("bp_req", 32'(bus.mem_rd_req), 32'd1);
            chk("bp_addr", bus.mem_rd_addr, line);
            chk("bp_ready", 32'(bus.icache_ready), 32'd0);
         end
         bus.mem_rd_ready = 1'b1;
         @(negedge clk);
         bus.mem_rd_ready = 1'b0;
         chk("req_dropped", 32'(bus.mem_rd_req), 32'd0);
         for (int b = 0; b < 4; b++) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = mem_word(line + 32'(b * 4));
            bus.mem_rd_last  = (b == 3);
            bus.icache_inv   = (b == inv_beat);
            @(negedge clk);
         end
         bus.mem_rd_valid = 1'b0;
         bus.mem_rd_last  = 1'b0;
         bus.icache_inv   = 1'b0;
         chk("miss_resp_valid", 32'(bus.icache_resp_valid), 32'd1);
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0; n_resp = 0; n_fetch = 0; hit_exp = 0; miss_exp = 0;
      resetn = 1'b0;
      bus.icache_req = 1'b0; bus.icache_addr = '0; bus.icache_inv = 1'b0;
      bus.mem_rd_ready = 1'b0; bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0; bus.mem_rd_last = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(bus.icache_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.icache_resp_valid), 32'd0);
      chk("rst_inst", bus.icache_inst, 32'd0);
      chk("rst_mem_req", 32'(bus.mem_rd_req), 32'd0);
      chk("rst_mem_addr", bus.mem_rd_addr, 32'd0);
      resetn = 1'b1;

      fetch(32'h0000_0008, 1'b1, 0, -1, 1'b0);   // cold miss, inst 0x33
      fetch(32'h0000_000C, 1'b0, 0, -1, 1'b0);   // hit, inst 0x44
      fetch(32'h0000_0100, 1'b1, 0, -1, 1'b0);   // conflict on idx 0
      fetch(32'h0000_0000, 1'b1, 0, -1, 1'b0);   // evicted line misses again
      fetch(32'h0000_010C, 1'b1, 5, -1, 1'b0);   // back-pressure, last-word request
      fetch(32'h0000_0104, 1'b0, 0, -1, 1'b0);
      fetch(32'h0000_0014, 1'b1, 0, 2, 1'b0);    // inv during beat 2
      fetch(32'h0000_0014, 1'b1, 0, -1, 1'b0);   // line was left invalid
      fetch(32'h0000_0018, 1'b0, 0, -1, 1'b0);
      fetch(32'h0000_001C, 1'b0, 0, -1, 1'b1);   // inv alongside a lookup hit
      fetch(32'h0000_0010, 1'b1, 0, -1, 1'b0);
      @(negedge clk);
      bus.icache_inv = 1'b1;                     // inv while idle
      @(negedge clk);
      bus.icache_inv = 1'b0;
      fetch(32'h0000_0010, 1'b1, 0, -1, 1'b0);
`ifdef ICACHE_PERF_EN
      chk("perf_hit", perf_hit, 32'(hit_exp));
      chk("perf_miss", perf_miss, 32'(miss_exp));
`endif

      // Reset in the middle of a refill of 0x20.
      @(negedge clk);
      bus.icache_req = 1'b1; bus.icache_addr = 32'h0000_0020;
      @(negedge clk);
      bus.icache_req = 1'b0;
      @(negedge clk);
      chk("rmid_req", 32'(bus.mem_rd_req), 32'd1);
      bus.mem_rd_ready = 1'b1;
      @(negedge clk);
      bus.mem_rd_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         bus.mem_rd_valid = 1'b1;
         bus.mem_rd_data  = 32'hDEAD_0000 + 32'(b);
         @(negedge clk);
      end
      bus.mem_rd_valid = 1'b0;
      resetn = 1'b0;
      #1;
      chk("rmid_ready", 32'(bus.icache_ready), 32'd1);
      chk("rmid_inst", bus.icache_inst, 32'd0);
      chk("rmid_mem_req", 32'(bus.mem_rd_req), 32'd0);
      chk("rmid_mem_addr", bus.mem_rd_addr, 32'd0);
      hit_exp = 0; miss_exp = 0;
`ifdef ICACHE_PERF_EN
      chk("rmid_perf_hit", perf_hit, 32'd0);
      chk("rmid_perf_miss", perf_miss, 32'd0);
`endif
      @(negedge clk);
      resetn = 1'b1;
      fetch(32'h0000_0020, 1'b1, 0, -1, 1'b0);
      fetch(32'h0000_0024, 1'b0, 0, -1, 1'b0);
`ifdef ICACHE_PERF_EN
      chk("end_perf_hit", perf_hit, 32'(hit_exp));
      chk("end_perf_miss", perf_miss, 32'(miss_exp));
`endif

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      chk("resp_count", 32'(n_resp), 32'(n_fetch));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
